scan_select_sequencer: RTL and testbench
========================================

Name: scan_select_sequencer

Overview:
- Sequential select generator directly upstream of the team's active-low 2-to-4 mixed-logic decoder.
- Steps through the four decoder channels in ascending order, skipping masked-off channels, and holds each select code for a programmable dwell.
- Inserts one blanking cycle at every select change so that downstream consumers gate on sel_valid and never act on a decode glitch.
- Supports single-pass and continuous modes, with start/stop control and an end-of-pass pulse.

Parameters:
DWELL_W, 8, width of the dwell-count input; the maximum dwell is 2^DWELL_W - 1 cycles.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  level-sampled request to begin a scan; honoured only in IDLE.
stop  input  1  abort request; takes priority over every other input.
single  input  1  sampled with start. 1 = one pass then IDLE; 0 = continuous.
ch_mask  input  4  bit i set = channel i is included. Sampled with start.
dwell  input  DWELL_W  cycles of sel_valid per channel. Sampled with start. A value of 0 is treated as 1.
s0  output  1  decoder select MSB; channel index = {s0,s1}.
s1  output  1  decoder select LSB.
sel_valid  output  1  high while the current select is stable and usable.
busy  output  1  high in any state other than IDLE.
pass_done  output  1  one-cycle pulse after the highest enabled channel completes its dwell.

Behaviour:
- Reset (asynchronous, rst_n low): state = IDLE; s0 = s1 = 0; sel_valid = 0; busy = 0; pass_done = 0; latched mask, dwell and single cleared; counter = 0.
- All outputs are registered.
- States:
  - IDLE: s0/s1 hold their last value. If start = 1, stop = 0 and ch_mask != 0:
    - latch ch_mask, single and max(dwell,1);
    - load {s0,s1} with the lowest enabled channel;
    - go to BLANK.
  - start with ch_mask = 0 is ignored; the block stays in IDLE and busy stays 0.
  - BLANK: exactly one cycle. sel_valid = 0; the new select is already on s0/s1. Load the counter with the latched dwell minus 1, then go to DWELL.
  - DWELL: sel_valid = 1; the counter decrements each cycle. On the cycle where counter = 0, compute next = lowest enabled channel strictly above the current one.
    - If next exists: load it and go to BLANK.
    - If no next exists (wrap), the pass is complete:
      - assert pass_done in the following cycle;
      - if single, go to IDLE;
      - otherwise load the lowest enabled channel and go to BLANK.
- Latency: start sampled in cycle 0 → BLANK in cycle 1 → sel_valid high for cycles 2 through dwell+1.
- Per-channel period = dwell + 1 cycles.
- A single-bit mask in continuous mode re-blanks on the same code each pass; s0/s1 are unchanged and sel_valid drops for 1 cycle.
- stop in BLANK or DWELL:
  - next cycle: IDLE, sel_valid = 0, busy = 0;
  - s0/s1 hold;
  - pass_done is not asserted, even if the stop coincides with the final dwell cycle.
- stop in IDLE has no effect.
- start while busy is ignored. Changes to ch_mask, dwell or single mid-scan have no effect until the next start.
- start and stop high together in IDLE: the block stays in IDLE.
- pass_done and sel_valid are never high in the same cycle (pass_done coincides with BLANK or IDLE).
- Reset asserted mid-scan forces the reset values immediately, independent of clk.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE = 2'd0, BLANK = 2'd1, DWELL = 2'd2;
  - the channel count constant NCH = 4;
  - the select width constant SEL_W = 2.
- One sub-module, next_channel_pick: combinational function of (mask, current index, wrap-from-lowest flag) returning next index and a wrap flag. It is reused for both the initial pick and the advance pick.

Test Plan:
1. Reset: drive rst_n low mid-DWELL, asynchronously with no clock edge → s0 = s1 = sel_valid = busy = pass_done = 0 immediately.
2. Full single pass: ch_mask = 4'b1111, dwell = 3, single = 1, start pulse at cycle 0.
   - {s0,s1} = 0,1,2,3, each with 3 cycles of sel_valid separated by one BLANK.
   - pass_done pulses in cycle 17; busy falls the same cycle.
3. Skipping: ch_mask = 4'b1010, dwell = 2, continuous.
   - Select sequence 1,3,1,3…; pass_done after every channel-3 dwell.
   - Decoder output d1 low, then d3 low, and so on.
4. Zero dwell and empty mask:
   - dwell = 0, ch_mask = 4'b0100 → sel_valid high 1 cycle per period, s0s1 = 10, alternating with 1 BLANK.
   - start with ch_mask = 0 → busy stays 0.
5. Stop priority: assert stop on the last DWELL cycle of channel 3 → IDLE next cycle, no pass_done, s0s1 holds 11. Assert start and stop together in IDLE → no activity.
6. Mid-scan changes: change ch_mask and dwell during a scan → the sequence is unchanged. A start pulse while busy is ignored; the next start after IDLE uses the new values.

Source files
------------

// File: rtl/scan_select_sequencer_pkg.sv
// Shared constants and state encoding for the scan select sequencer.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package scan_select_sequencer_pkg;

    // Number of decoder channels and the width of the select code driving them
    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    // Sequencer states; encoding is fixed so other blocks can decode a tapped state bus
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DWELL = 2'd2
    } state_t;

endpackage

// File: rtl/scan_select_sequencer_next_channel_pick.sv
// Picks the next enabled channel: lowest set mask bit, either from index 0 or strictly above cur.
// Latency: purely combinational.
// Backpressure: none; wrap is raised when no qualifying channel exists.
module next_channel_pick
    import scan_select_sequencer_pkg::*;
(
    input  logic [NCH-1:0]   mask,
    input  logic [SEL_W-1:0] cur,
    input  logic             from_lowest,
    output logic [SEL_W-1:0] nxt,
    output logic             wrap
);

    logic found;

    // Priority scan from channel 0 upward; the first qualifying channel wins
    always_comb begin
        nxt   = '0;
        found = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (!found && mask[i] && (from_lowest || (SEL_W'(i) > cur))) begin
                nxt   = SEL_W'(i);
                found = 1'b1;
            end
        end
        wrap = !found;
    end

endmodule

// File: rtl/scan_select_sequencer.sv
// Steps a 2-bit decoder select through enabled channels, one blanking cycle per change, programmable dwell.
// Latency: start sampled in cycle 0 -> BLANK in cycle 1 -> sel_valid in cycles 2..dwell+1; all outputs registered.
// Backpressure: none; start ignored while busy, stop aborts to IDLE next cycle with priority over everything.
module scan_select_sequencer
    import scan_select_sequencer_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               single,
    input  logic [NCH-1:0]     ch_mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic               s0,
    output logic               s1,
    output logic               sel_valid,
    output logic               busy,
    output logic               pass_done
);

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [NCH-1:0]     mask_q, mask_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               single_q, single_d;
    logic               pass_done_d;
    logic               sel_valid_q;
    logic               busy_q;
    logic               pass_done_q;

    logic [NCH-1:0]     first_mask;
    logic [SEL_W-1:0]   first_idx;
    logic               first_none;
    logic [SEL_W-1:0]   adv_idx;
    logic               adv_wrap;

    // In IDLE the live mask is searched so the very first select is ready at BLANK;
    // during a scan only the latched mask matters (restart after wrap).
    assign first_mask = (state_q == IDLE) ? ch_mask : mask_q;

    next_channel_pick u_first_pick (
        .mask        (first_mask),
        .cur         (sel_q),
        .from_lowest (1'b1),
        .nxt         (first_idx),
        .wrap        (first_none)
    );

    next_channel_pick u_adv_pick (
        .mask        (mask_q),
        .cur         (sel_q),
        .from_lowest (1'b0),
        .nxt         (adv_idx),
        .wrap        (adv_wrap)
    );

    // Next-state, select and dwell counter; stop is checked first in every active state
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        mask_d      = mask_q;
        dwell_d     = dwell_q;
        cnt_d       = cnt_q;
        single_d    = single_q;
        pass_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                // first_none doubles as the empty-mask check
                if (start && !stop && !first_none) begin
                    mask_d   = ch_mask;
                    single_d = single;
                    dwell_d  = (dwell == '0) ? DWELL_W'(1) : dwell;
                    sel_d    = first_idx;
                    state_d  = BLANK;
                end
            end
            BLANK: begin
                if (stop) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = dwell_q - DWELL_W'(1);
                    state_d = DWELL;
                end
            end
            DWELL: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else if (!adv_wrap) begin
                    sel_d   = adv_idx;
                    state_d = BLANK;
                end else begin
                    pass_done_d = 1'b1;
                    if (single_q) begin
                        state_d = IDLE;
                    end else begin
                        sel_d   = first_idx;
                        state_d = BLANK;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; sel_valid/busy are registered from the next state so they align with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            mask_q      <= '0;
            dwell_q     <= '0;
            cnt_q       <= '0;
            single_q    <= 1'b0;
            sel_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            pass_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            mask_q      <= mask_d;
            dwell_q     <= dwell_d;
            cnt_q       <= cnt_d;
            single_q    <= single_d;
            sel_valid_q <= (state_d == DWELL);
            busy_q      <= (state_d != IDLE);
            pass_done_q <= pass_done_d;
        end
    end

    assign s0        = sel_q[1];
    assign s1        = sel_q[0];
    assign sel_valid = sel_valid_q;
    assign busy      = busy_q;
    assign pass_done = pass_done_q;

endmodule

// File: tb/tb_scan_select_sequencer.sv
// Directed bench for the scan select sequencer with a per-cycle expected-output scoreboard.
// Latency: expectations are queued for cycle 1 onward relative to the start-sampling edge.
// Backpressure: not applicable; the bench only drives start/stop.
module tb_scan_select_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       single;
    logic [3:0] ch_mask;
    logic [7:0] dwell;
    logic       s0, s1, sel_valid, busy, pass_done;

    int checks = 0;
    int errors = 0;
    string tag = "reset";
    logic [4:0] expq[$];   // {s0,s1,sel_valid,busy,pass_done} per cycle

    scan_select_sequencer #(.DWELL_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .single    (single),
        .ch_mask   (ch_mask),
        .dwell     (dwell),
        .s0        (s0),
        .s1        (s1),
        .sel_valid (sel_valid),
        .busy      (busy),
        .pass_done (pass_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0t observed {s0s1,vld,busy,pd}=%b required %b", name, $time, obs, exp);
        end
    endtask

    // Advance one clock and compare the outputs against the head of the scoreboard
    task automatic tick();
        logic [4:0] e;
        @(posedge clk);
        #1;
        if (expq.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard underflow observed %b required none", tag, {s0, s1, sel_valid, busy, pass_done});
        end else begin
            e = expq.pop_front();
            check(tag, {s0, s1, sel_valid, busy, pass_done}, e);
        end
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drain();
        while (expq.size() > 0) tick();
    endtask

    // Reference behaviour: per enabled channel one BLANK then max(dwell,1) valid cycles;
    // pass_done rides on the restart BLANK (continuous) or on the IDLE cycle (single).
    task automatic push_scan(input logic [3:0] m, input int dw, input bit sgl, input int passes);
        int d;
        bit first;
        logic [1:0] c;
        logic [1:0] last;
        d = (dw == 0) ? 1 : dw;
        last = 2'd0;
        for (int p = 0; p < passes; p++) begin
            first = 1'b1;
            for (int ch = 0; ch < 4; ch++) begin
                if (m[ch]) begin
                    c = 2'(ch);
                    expq.push_back({c, 1'b0, 1'b1, (p > 0) && first});
                    first = 1'b0;
                    for (int k = 0; k < d; k++) expq.push_back({c, 1'b1, 1'b1, 1'b0});
                    last = c;
                end
            end
        end
        if (sgl) expq.push_back({last, 1'b0, 1'b0, 1'b1});
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        single  = 1'b0;
        ch_mask = 4'b0000;
        dwell   = 8'd0;
        #12;
        check("reset_values", {s0, s1, sel_valid, busy, pass_done}, 5'b00000);
        @(negedge clk);
        rst_n = 1'b1;

        // Full single pass over all four channels, dwell 3: pass_done in cycle 17
        tag = "single_pass_1111";
        ch_mask = 4'b1111; dwell = 8'd3; single = 1'b1; start = 1'b1;
        push_scan(4'b1111, 3, 1'b1, 1);
        tick();
        start = 1'b0;
        drain();

        // Skipping mask in continuous mode, then stop on the final dwell cycle of channel 3
        tag = "skip_1010_cont";
        ch_mask = 4'b1010; dwell = 8'd2; single = 1'b0; start = 1'b1;
        push_scan(4'b1010, 2, 1'b0, 3);
        tick();
        start = 1'b0;
        drain();
        tag = "stop_last_dwell";
        stop = 1'b1;
        expq.push_back({2'b11, 1'b0, 1'b0, 1'b0});
        tick();
        stop = 1'b0;
        expq.push_back({2'b11, 1'b0, 1'b0, 1'b0});
        tick();

        // Zero dwell on a single channel: valid one cycle, blank one cycle, same code
        tag = "zero_dwell_0100";
        ch_mask = 4'b0100; dwell = 8'd0; single = 1'b0; start = 1'b1;
        push_scan(4'b0100, 0, 1'b0, 3);
        tick();
        start = 1'b0;
        drain();
        stop = 1'b1;
        expq.push_back({2'b10, 1'b0, 1'b0, 1'b0});
        tick();
        stop = 1'b0;

        // Empty mask start is ignored
        tag = "empty_mask_start";
        ch_mask = 4'b0000; dwell = 8'd2; start = 1'b1;
        repeat (3) expq.push_back({2'b10, 1'b0, 1'b0, 1'b0});
        tick_n(3);
        start = 1'b0;

        // Start and stop together in IDLE
        tag = "start_stop_idle";
        ch_mask = 4'b1111; start = 1'b1; stop = 1'b1;
        repeat (3) expq.push_back({2'b10, 1'b0, 1'b0, 1'b0});
        tick_n(3);
        start = 1'b0; stop = 1'b0;

        // Mid-scan input changes and start-while-busy are ignored
        tag = "midscan_changes";
        ch_mask = 4'b1001; dwell = 8'd2; single = 1'b1; start = 1'b1;
        push_scan(4'b1001, 2, 1'b1, 1);
        tick();
        start = 1'b0;
        ch_mask = 4'b0110; dwell = 8'd1; single = 1'b1;
        tick_n(2);
        start = 1'b1;
        tick_n(2);
        start = 1'b0;
        drain();

        // Next start after IDLE picks up the new configuration
        tag = "new_config_0110";
        start = 1'b1;
        push_scan(4'b0110, 1, 1'b1, 1);
        tick();
        start = 1'b0;
        drain();

        // Asynchronous reset in the middle of a dwell, between clock edges
        tag = "async_reset";
        ch_mask = 4'b1111; dwell = 8'd3; single = 1'b1; start = 1'b1;
        push_scan(4'b1111, 3, 1'b1, 1);
        tick();
        start = 1'b0;
        tick_n(2);
        expq.delete();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_now", {s0, s1, sel_valid, busy, pass_done}, 5'b00000);
        @(negedge clk);
        rst_n = 1'b1;
        expq.push_back(5'b00000);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
